dmem_responder: RTL

- Responder (memory) end of the core's load/store interface.
- Accepts one request at a time from the datapath's memory stage: byte address, funct3 size/sign code, write flag and store data.
- Performs the access on a byte-enabled word array after a configurable number of wait states.
- Returns load data or an error flag through a valid/ready response handshake.

---
 rtl/dmem_responder_pkg.sv | 34 +++
 rtl/dmem_responder_array.sv | 31 +++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the core's
// writeback path: funct3 size/sign codes, responder FSM states and the
// load sign/zero extension helper.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Extend a right-aligned load value according to funct3.
    // Illegal codes yield zero.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [31:0] shifted);
        logic [31:0] result;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = shifted;
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Byte-enabled word array behind the data-memory responder.
// Ports:
//   clk      write clock
//   i_be     per-byte write enables (lane 0 = bits [7:0])
//   i_idx    word index, shared by read and write
//   i_wdata  write data, already steered into lanes
//   o_rdata  combinational read of word i_idx
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's load/store interface. Accepts one request,
// waits WAIT_CYCLES cycles, commits the access on the edge entering RESP,
// then holds the response until rsp_ready.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we               1 = store, 0 = load
//   req_addr             byte address
//   req_funct3           RISC-V load/store size/sign code
//   req_wdata            right-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data, 0 for stores and errors
//   rsp_err              misaligned, illegal funct3 or out-of-range
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic             w_commit;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [2:0]       w_funct3;
    logic [31:0]      w_wdata;
    logic             w_f3_ok;
    logic             w_misalign;
    logic             w_range_err;
    logic             w_err;
    logic [3:0]       w_lane_be;
    logic [31:0]      w_lane_wdata;
    logic [3:0]       w_array_be;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rdword;
    logic [31:0]      w_load;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // With zero wait states the commit happens on the accept edge, before
    // the request fields are latched, so the access path reads the live
    // request in IDLE and the latched copy otherwise.
    assign w_commit = ((r_state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((r_state == ST_WAIT) && (r_cnt == 4'd0));

    always_comb begin
        if (r_state == ST_IDLE) begin
            w_we     = req_we;
            w_addr   = req_addr;
            w_funct3 = req_funct3;
            w_wdata  = req_wdata;
        end else begin
            w_we     = r_we;
            w_addr   = r_addr;
            w_funct3 = r_funct3;
            w_wdata  = r_wdata;
        end
    end

    always_comb begin
        w_f3_ok      = 1'b0;
        w_misalign   = 1'b0;
        w_lane_be    = 4'b1111;
        w_lane_wdata = w_wdata;
        case (w_funct3)
            F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
            F3_BU, F3_HU:     w_f3_ok = !w_we;
            default:          w_f3_ok = 1'b0;
        endcase
        case (w_funct3[1:0])
            2'b00: begin
                w_lane_be    = 4'b0001 << w_addr[1:0];
                w_lane_wdata = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_misalign   = w_addr[0];
                w_lane_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{w_wdata[15:0]}};
            end
            default: begin
                w_misalign   = |w_addr[1:0];
            end
        endcase
    end

    assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err       = !w_f3_ok || w_misalign || w_range_err;
    assign w_array_be  = (w_commit && w_we && !w_err) ? w_lane_be : '0;
    assign w_idx       = w_addr[IDX_W+1:2];
    assign w_load      = load_extend(w_funct3, w_rdword >> {w_addr[1:0], 3'b000});

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .i_be   (w_array_be),
        .i_idx  (w_idx),
        .i_wdata(w_lane_wdata),
        .o_rdata(w_rdword)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_commit) begin
                r_rdata <= (w_err || w_we) ? '0 : w_load;
                r_err   <= w_err;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
